ntt_bfu: RTL and testbench

Pipelined modular butterfly unit sitting directly downstream of the NTT address generator. It consumes the generator's `bfu_en` beat, the two coefficients read from the RAM banks, and the twiddle from the ROM. It produces the two butterfly results, which are written back with write addresses and the bank-select flag delay-matched. It supports Cooley-Tukey (forward NTT) and Gentleman-Sande (inverse NTT) butterflies, with fixed latency in both modes.

---
 rtl/ntt_pkg.sv | 26 ++
 rtl/ntt_bfu_barrett_red.sv | 43 ++++
 rtl/ntt_bfu.sv | 109 ++++++++++
 tb/tb_ntt_bfu.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and side-band record for the NTT datapath.
// Barrett constant M is derived from the modulus at elaboration.
package ntt_pkg;

  localparam int Q  = 3329;
  localparam int DW = 12;
  localparam int AW = 7;
  localparam int K  = 2 * DW;

  function automatic int barrett_m(input int q, input int k);
    return (1 << k) / q;
  endfunction

  localparam int M  = barrett_m(Q, K);
  localparam int MW = $clog2(M + 1);

  typedef struct packed {
    logic          valid;
    logic          inv;
    logic [DW-1:0] as;
    logic [AW-1:0] waddr0;
    logic [AW-1:0] waddr1;
    logic          wsel;
  } sb_t;

endpackage

// File: rtl/ntt_bfu_barrett_red.sv
// Two-stage Barrett reduction from [0, Q^2) to [0, Q).
// Valid bit travels alongside the data.
module barrett_red
  import ntt_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [2*DW-1:0] p,
  output logic            out_valid,
  output logic [DW-1:0]   t
);

  localparam logic [MW-1:0]   MV = MW'(M);
  localparam logic [2*DW-1:0] QP = (2*DW)'(Q);
  localparam logic [DW:0]     QR = (DW+1)'(Q);

  logic [2*DW+MW-1:0] pm;
  logic [2*DW-1:0]    qh;
  logic [2*DW-1:0]    rw;
  logic [DW:0]        r_q;
  logic               v_q;

  assign pm = {{MW{1'b0}}, p} * {{(2*DW){1'b0}}, MV};
  assign qh = (2*DW)'(pm >> K);
  // r lands in [0, 2Q), so DW+1 bits hold it exactly
  assign rw = p - qh * QP;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q       <= 1'b0;
      r_q       <= '0;
      out_valid <= 1'b0;
      t         <= '0;
    end else begin
      v_q       <= in_valid;
      r_q       <= (DW+1)'(rw);
      out_valid <= v_q;
      t         <= (r_q >= QR) ? DW'(r_q - QR) : DW'(r_q);
    end
  end

endmodule

// File: rtl/ntt_bfu.sv
// Five-stage CT/GS modular butterfly with delay-matched
// write-back addresses and bank flag.
module ntt_bfu
  import ntt_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          bfu_en,
  input  logic          inv,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  input  logic [DW-1:0] w_in,
  input  logic [AW-1:0] waddr0_in,
  input  logic [AW-1:0] waddr1_in,
  input  logic          wsel_in,
  output logic          out_valid,
  output logic [DW-1:0] x_out,
  output logic [DW-1:0] y_out,
  output logic [AW-1:0] w_addr_0,
  output logic [AW-1:0] w_addr_1,
  output logic          w_ram_flag_out,
  output logic          busy
);

  localparam logic [DW:0] QX = (DW+1)'(Q);

  sb_t             sb_in, sb1, sb2, sb3, sb4;
  logic [DW:0]     sum1, dif1, sum5, dif5;
  logic [DW-1:0]   s_c, d_c, m1_d, m1_q, w_q;
  logic [DW-1:0]   x_c, y_c, t4;
  logic [2*DW-1:0] p_q;
  logic            bv4;

  always_comb begin
    sum1 = {1'b0, a_in} + {1'b0, b_in};
    dif1 = {1'b0, a_in} - {1'b0, b_in};
    s_c  = (sum1 >= QX) ? DW'(sum1 - QX) : DW'(sum1);
    d_c  = (a_in >= b_in) ? DW'(dif1) : DW'(dif1 + QX);
    m1_d = inv ? d_c : b_in;
    sb_in.valid  = bfu_en;
    sb_in.inv    = inv;
    sb_in.as     = inv ? s_c : a_in;
    sb_in.waddr0 = waddr0_in;
    sb_in.waddr1 = waddr1_in;
    sb_in.wsel   = wsel_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb1  <= '0;
      sb2  <= '0;
      sb3  <= '0;
      sb4  <= '0;
      m1_q <= '0;
      w_q  <= '0;
      p_q  <= '0;
    end else begin
      sb1  <= sb_in;
      sb2  <= sb1;
      sb3  <= sb2;
      sb4  <= sb3;
      m1_q <= m1_d;
      w_q  <= w_in;
      p_q  <= {{DW{1'b0}}, m1_q} * {{DW{1'b0}}, w_q};
    end
  end

  barrett_red u_red (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (sb2.valid),
    .p         (p_q),
    .out_valid (bv4),
    .t         (t4)
  );

  always_comb begin
    sum5 = {1'b0, sb4.as} + {1'b0, t4};
    dif5 = {1'b0, sb4.as} - {1'b0, t4};
    x_c  = (sum5 >= QX) ? DW'(sum5 - QX) : DW'(sum5);
    y_c  = (sb4.as >= t4) ? DW'(dif5) : DW'(dif5 + QX);
    if (sb4.inv) begin
      x_c = sb4.as;
      y_c = t4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      x_out          <= '0;
      y_out          <= '0;
      w_addr_0       <= '0;
      w_addr_1       <= '0;
      w_ram_flag_out <= 1'b0;
    end else begin
      out_valid      <= bv4;
      x_out          <= x_c;
      y_out          <= y_c;
      w_addr_0       <= sb4.waddr0;
      w_addr_1       <= sb4.waddr1;
      w_ram_flag_out <= sb4.wsel;
    end
  end

  assign busy = sb1.valid | sb2.valid | sb3.valid
              | sb4.valid | out_valid;

endmodule

// File: tb/tb_ntt_bfu.sv
// Randomized bench for ntt_bfu against a cycle-indexed
// behavioural model of the butterfly and its timing.
module tb_ntt_bfu;

  localparam int Q = 3329;
  localparam int N = 1024;

  logic        clk = 1'b0;
  logic        rst, bfu_en, inv, wsel_in;
  logic [11:0] a_in, b_in, w_in;
  logic [6:0]  waddr0_in, waddr1_in;
  logic        out_valid, w_ram_flag_out, busy;
  logic [11:0] x_out, y_out;
  logic [6:0]  w_addr_0, w_addr_1;

  ntt_bfu dut (
    .clk            (clk),
    .rst            (rst),
    .bfu_en         (bfu_en),
    .inv            (inv),
    .a_in           (a_in),
    .b_in           (b_in),
    .w_in           (w_in),
    .waddr0_in      (waddr0_in),
    .waddr1_in      (waddr1_in),
    .wsel_in        (wsel_in),
    .out_valid      (out_valid),
    .x_out          (x_out),
    .y_out          (y_out),
    .w_addr_0       (w_addr_0),
    .w_addr_1       (w_addr_1),
    .w_ram_flag_out (w_ram_flag_out),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit en_h[N], rst_h[N], inv_h[N];
  int a_h[N], b_h[N], w_h[N], wa0_h[N], wa1_h[N], ws_h[N];
  int tests = 0;
  int fails = 0;
  bit done  = 0;

  function automatic void bfly(input bit iv, input int a, b, w,
                               output int x, output int y);
    int t;
    if (!iv) begin
      t = (b * w) % Q;
      x = (a + t) % Q;
      y = (a - t + Q) % Q;
    end else begin
      x = (a + b) % Q;
      y = (((a - b + Q) % Q) * w) % Q;
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d",
               nm, cyc, act, exp);
    end
  endtask

  // A beat issued in cycle j reaches the output in cycle j+5
  // unless reset is asserted in any cycle j..k-1.
  function automatic bit alive(input int j, input int k);
    if (j < 0) return 1'b0;
    if (!en_h[j]) return 1'b0;
    for (int i = j; i < k; i++)
      if (rst_h[i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    int k, j, ex, ey;
    bit ev, be;
    if (cyc >= 1 && !done) begin
      k  = cyc;
      ev = alive(k - 5, k);
      be = 1'b0;
      for (int i = 1; i <= 5; i++) be |= alive(k - i, k);
      chk("out_valid", int'(out_valid), int'(ev));
      chk("busy", int'(busy), int'(be));
      if (rst_h[k-1]) begin
        chk("rst_x", int'(x_out), 0);
        chk("rst_y", int'(y_out), 0);
        chk("rst_wa0", int'(w_addr_0), 0);
        chk("rst_wa1", int'(w_addr_1), 0);
        chk("rst_flag", int'(w_ram_flag_out), 0);
      end else if (ev) begin
        j = k - 5;
        bfly(inv_h[j], a_h[j], b_h[j], w_h[j], ex, ey);
        chk("x_out", int'(x_out), ex);
        chk("y_out", int'(y_out), ey);
        chk("w_addr_0", int'(w_addr_0), wa0_h[j]);
        chk("w_addr_1", int'(w_addr_1), wa1_h[j]);
        chk("w_ram_flag", int'(w_ram_flag_out), ws_h[j]);
      end
    end
  end

  task automatic step(input bit r, input bit e, input bit iv,
                      input int a, input int b, input int w,
                      input int wa0, input int wa1, input int ws);
    @(posedge clk);
    #1;
    rst       = r;
    bfu_en    = e;
    inv       = iv;
    a_in      = 12'(a);
    b_in      = 12'(b);
    w_in      = 12'(w);
    waddr0_in = 7'(wa0);
    waddr1_in = 7'(wa1);
    wsel_in   = 1'(ws);
    rst_h[cyc] = r;
    en_h[cyc]  = e;
    inv_h[cyc] = iv;
    a_h[cyc]   = a;
    b_h[cyc]   = b;
    w_h[cyc]   = w;
    wa0_h[cyc] = wa0;
    wa1_h[cyc] = wa1;
    ws_h[cyc]  = ws;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rbeat(input bit iv, input bit r);
    step(r, 1'b1, iv,
         int'($urandom_range(Q - 1)), int'($urandom_range(Q - 1)),
         int'($urandom_range(Q - 1)), int'($urandom_range(127)),
         int'($urandom_range(127)), int'($urandom_range(1)));
  endtask

  initial begin
    int x, y;
    rst = 1'b1; bfu_en = 1'b0; inv = 1'b0; wsel_in = 1'b0;
    a_in = '0; b_in = '0; w_in = '0;
    waddr0_in = '0; waddr1_in = '0;
    rst_h[0] = 1'b1;

    bfly(1'b0, 5, 7, 2, x, y);
    chk("model_ct_x", x, 19);
    chk("model_ct_y", y, 3320);
    bfly(1'b1, 5, 7, 2, x, y);
    chk("model_gs_x", x, 12);
    chk("model_gs_y", y, 3325);
    bfly(1'b0, 3328, 3328, 3328, x, y);
    chk("model_ext_x", x, 0);
    chk("model_ext_y", y, 3327);

    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 5, 7, 2, 1, 2, 0);
    step(1'b0, 1'b1, 1'b1, 5, 7, 2, 3, 4, 1);
    step(1'b0, 1'b1, 1'b0, 3328, 3328, 3328, 5, 6, 0);
    step(1'b0, 1'b1, 1'b1, 100, 3000, 17, 'h12, 'h52, 1);
    step(1'b0, 1'b1, 1'b1, 3328, 3328, 3328, 7, 8, 0);
    idle(7);

    for (int i = 0; i < 8; i++) rbeat(1'(i), 1'b0);
    idle(2);
    for (int i = 0; i < 3; i++) rbeat(1'(i), 1'b0);
    idle(7);

    for (int i = 0; i < 3; i++) rbeat(1'(i), 1'b0);
    rbeat(1'b0, 1'b1);
    idle(5);
    rbeat(1'b1, 1'b0);
    idle(7);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(39) == 0)
        rbeat(1'($urandom_range(1)), 1'b1);
      else if ($urandom_range(3) != 0)
        rbeat(1'($urandom_range(1)), 1'b0);
      else
        idle(1);
    end
    idle(8);

    @(posedge clk);
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
